// File: rtl/eeprom_pkg.sv
// rtl/eeprom_pkg.sv - state encoding and shared constants for the EEPROM burst sequencer
package eeprom_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_ACK,
    S_TWR,
    S_GAP
  } seq_state_t;

  localparam int TWR_CYCLES_DEF  = 50000;
  localparam int ACK_TIMEOUT_DEF = 65535;

  localparam logic [2:0] EEPROM_DEV_ID = 3'b000;

endpackage

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - loadable down-counter; expired is high whenever the count sits at zero
module seq_timer
  import eeprom_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/eeprom_seq.sv
// rtl/eeprom_seq.sv - splits 1..256 byte bursts into single-byte I2C engine transactions
module eeprom_seq
  import eeprom_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int TWR_CYCLES  = TWR_CYCLES_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_len,
  input  logic [7:0]        wd_data,
  input  logic              wd_valid,
  output logic              wd_ready,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              i2c_wr,
  output logic              i2c_rd,
  output logic [ADDR_W-1:0] i2c_addr,
  output logic [7:0]        i2c_data_w,
  input  logic              i2c_ack,
  input  logic [7:0]        i2c_data_out
);

  localparam int TMR_MAX = (TWR_CYCLES > ACK_TIMEOUT) ? TWR_CYCLES : ACK_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // Both loads are one short because the counter's zero cycle is itself counted
  localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TWR_LOAD = TMR_W'(TWR_CYCLES - 1);

  seq_state_t       state;
  logic             is_write;
  logic [7:0]       remaining;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_expired;

  assign wd_ready = wd_valid && (state == S_FETCH);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = ACK_LOAD;
    if (state == S_ISSUE) begin
      tmr_load = 1'b1;
    end else if (state == S_WAIT_ACK && i2c_ack && is_write) begin
      tmr_load = 1'b1;
      tmr_val  = TWR_LOAD;
    end
  end

  seq_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      i2c_wr      <= 1'b0;
      i2c_rd      <= 1'b0;
      i2c_addr    <= '0;
      i2c_data_w  <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      is_write    <= 1'b0;
      remaining   <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      i2c_wr   <= 1'b0;
      i2c_rd   <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_ready && req_valid) begin
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            err_timeout <= 1'b0;
            i2c_addr    <= req_addr;
            remaining   <= req_len;
            is_write    <= req_write;
            state       <= req_write ? S_FETCH : S_ISSUE;
          end
        end
        S_FETCH: begin
          if (wd_valid) begin
            i2c_data_w <= wd_data;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          i2c_wr <= is_write;
          i2c_rd <= !is_write;
          state  <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // An ack in the expiry cycle still completes the byte
          if (i2c_ack) begin
            if (is_write) begin
              state <= S_TWR;
            end else begin
              rd_data  <= i2c_data_out;
              rd_valid <= 1'b1;
              state    <= S_GAP;
            end
          end else if (tmr_expired) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            req_ready   <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_TWR: begin
          if (tmr_expired) begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (remaining == 8'd0) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            i2c_addr  <= i2c_addr + ADDR_W'(1);
            remaining <= remaining - 8'd1;
            state     <= is_write ? S_FETCH : S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_seq.sv
// tb/tb_eeprom_seq.sv - directed and randomized bursts against an I2C engine model and burst reference
module tb_eeprom_seq;

  localparam int TWR = 200;
  localparam int ATO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic [7:0]  wd_data;
  logic        wd_valid;
  logic        wd_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic        i2c_wr;
  logic        i2c_rd;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic        i2c_ack;
  logic [7:0]  i2c_data_out;

  eeprom_seq #(.ADDR_W(16), .TWR_CYCLES(TWR), .ACK_TIMEOUT(ATO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .wd_data      (wd_data),
    .wd_valid     (wd_valid),
    .wd_ready     (wd_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .done         (done),
    .err_timeout  (err_timeout),
    .i2c_wr       (i2c_wr),
    .i2c_rd       (i2c_rd),
    .i2c_addr     (i2c_addr),
    .i2c_data_w   (i2c_data_w),
    .i2c_ack      (i2c_ack),
    .i2c_data_out (i2c_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] rmem [65536];
  bit         never_ack = 1'b0;
  int         ack_dly = 100;
  int         p_addr[$], p_data[$], p_wr[$], p_cyc[$], a_cyc[$];
  int         stab_bad = 0;
  logic [7:0] wd_q[$];
  int         stall = 0;
  logic [7:0] rd_q[$];
  int         rd_cyc[$];
  int         done_cnt = 0;
  logic [7:0] wsrc[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine model: acks ack_dly cycles after each pulse and watches addr/data hold
  initial begin
    logic [15:0] sa;
    logic [7:0]  sd;
    bit          sw;
    i2c_ack = 1'b0;
    i2c_data_out = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (i2c_wr || i2c_rd) begin
        sa = i2c_addr;
        sd = i2c_data_w;
        sw = i2c_wr;
        p_addr.push_back(int'(sa));
        p_data.push_back(int'(sd));
        p_wr.push_back(int'(sw));
        p_cyc.push_back(cyc);
        if (!never_ack) begin
          repeat (ack_dly) begin
            @(posedge clk);
            #1;
            if (i2c_addr !== sa || i2c_data_w !== sd) stab_bad++;
          end
          i2c_ack = 1'b1;
          i2c_data_out = sw ? 8'h00 : rmem[sa];
          a_cyc.push_back(cyc);
          @(posedge clk);
          #1;
          i2c_ack = 1'b0;
          i2c_data_out = 8'h00;
        end
      end
    end
  end

  // Write-byte source with an optional stall before the first byte
  initial begin
    bit acc;
    wd_valid = 1'b0;
    wd_data = 8'h00;
    forever begin
      @(negedge clk);
      acc = wd_valid && wd_ready;
      @(posedge clk);
      #1;
      if (acc) void'(wd_q.pop_front());
      if (stall > 0) stall--;
      wd_valid = (wd_q.size() > 0) && (stall == 0);
      wd_data = (wd_q.size() > 0) ? wd_q[0] : 8'h00;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      if (rd_valid) begin
        rd_q.push_back(rd_data);
        rd_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    p_addr.delete(); p_data.delete(); p_wr.delete(); p_cyc.delete(); a_cyc.delete();
    rd_q.delete(); rd_cyc.delete();
  endtask

  task automatic run_burst(input bit w, input logic [15:0] a, input logic [7:0] len,
                           input int stall_n, input bit hold);
    int base_done, n, req_cyc, budget, ea, np;
    logic [7:0] exp_w[$];
    clear_logs();
    exp_w.delete();
    if (w) begin
      if (wsrc.size() == int'(len) + 1) exp_w = wsrc;
      else for (int i = 0; i <= int'(len); i++) exp_w.push_back(8'($urandom));
    end
    wsrc.delete();
    stall = stall_n;
    wd_q = exp_w;
    base_done = done_cnt;
    tick();
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_len = len;
    req_cyc = cyc;
    tick();
    chk("accept_busy", busy, 1);
    chk("accept_ready_low", req_ready, 0);
    chk("accept_err_clear", err_timeout, 0);
    if (!hold) req_valid = 1'b0;
    else req_addr = 16'($urandom);
    budget = (int'(len) + 1) * (ack_dly + TWR + 20) + stall_n + 100;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
      if (hold && n == 5) chk("ready_low_while_busy", req_ready, 0);
    end
    req_valid = 1'b0;
    chk("done_seen", done, 1);
    chk("busy_clear", busy, 0);
    chk("err_clear_end", err_timeout, 0);
    repeat (4) tick();
    chk("done_once", done_cnt - base_done, 1);
    np = p_addr.size();
    chk("pulse_count", np, int'(len) + 1);
    chk("addr_stable", stab_bad, 0);
    if (np > 0) begin
      if (stall_n == 0) chk("first_pulse_latency", p_cyc[0] - req_cyc, w ? 3 : 2);
      else chk("no_pulse_in_stall", (p_cyc[0] - req_cyc) >= stall_n, 1);
    end
    for (int i = 0; i < np && i <= int'(len); i++) begin
      ea = (int'(a) + i) % 65536;
      chk($sformatf("addr[%0d]", i), p_addr[i], ea);
      chk($sformatf("kind[%0d]", i), p_wr[i], int'(w));
      if (w) begin
        chk($sformatf("wdata[%0d]", i), p_data[i], int'(exp_w[i]));
        if (i > 0) chk($sformatf("twr_gap[%0d]", i), (p_cyc[i] - a_cyc[i-1]) >= TWR, 1);
      end else if (i < rd_q.size()) begin
        chk($sformatf("rdata[%0d]", i), rd_q[i], rmem[ea]);
        chk($sformatf("rd_latency[%0d]", i), rd_cyc[i] - a_cyc[i], 1);
      end
    end
    if (!w) chk("rd_count", rd_q.size(), int'(len) + 1);
  endtask

  initial begin
    int n, base, pc, dcyc;
    for (int i = 0; i < 65536; i++) rmem[i] = 8'($urandom);
    rmem[16'h0100] = 8'h11; rmem[16'h0101] = 8'h22;
    rmem[16'h0102] = 8'h33; rmem[16'h0103] = 8'h44;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_rd", {i2c_wr, i2c_rd, rd_valid, err_timeout}, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", req_ready, 1);

    ack_dly = 100;
    wsrc = '{8'hA5, 8'h5A, 8'hC3};
    run_burst(1'b1, 16'h0010, 8'd2, 0, 1'b0);
    run_burst(1'b0, 16'h0100, 8'd3, 0, 1'b0);
    run_burst(1'b0, 16'hFFFF, 8'd1, 0, 1'b0);

    // Timeout: a read burst whose first byte is never acked
    never_ack = 1'b1;
    clear_logs();
    base = done_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'($urandom); req_len = 8'd3;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!done && n < ATO + 200) begin tick(); n++; end
    dcyc = cyc;
    chk("to_done", done, 1);
    chk("to_err", err_timeout, 1);
    chk("to_pulses", p_cyc.size(), 1);
    pc = (p_cyc.size() > 0) ? p_cyc[0] : -99999;
    chk("to_latency", dcyc - pc, ATO);
    repeat (20) tick();
    chk("to_err_sticky", err_timeout, 1);
    chk("to_done_once", done_cnt - base, 1);
    chk("to_no_rd", rd_q.size(), 0);
    never_ack = 1'b0;
    run_burst(1'b0, 16'h2000, 8'd0, 0, 1'b0);

    // Ack in the very cycle the timeout would fire
    ack_dly = ATO - 1;
    run_burst(1'b0, 16'h3456, 8'd0, 0, 1'b0);

    ack_dly = 40;
    run_burst(1'b1, 16'h0400, 8'd1, 500, 1'b1);

    // Reset while waiting for an ack
    never_ack = 1'b1;
    clear_logs();
    base = done_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0777; req_len = 8'd4;
    wd_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    tick();
    req_valid = 1'b0;
    n = 0;
    while (p_cyc.size() == 0 && n < 50) begin tick(); n++; end
    chk("rst_mid_pulse_seen", p_cyc.size(), 1);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wr_rd", {i2c_wr, i2c_rd}, 0);
    chk("rst_mid_ready", req_ready, 0);
    rst = 1'b0;
    wd_q.delete();
    tick();
    chk("rst_mid_ready_after", req_ready, 1);
    repeat (5) tick();
    chk("rst_mid_no_done", done_cnt - base, 0);
    never_ack = 1'b0;

    repeat (6) begin
      ack_dly = $urandom_range(3, 150);
      run_burst(1'($urandom), ($urandom_range(0, 2) == 0) ? 16'hFFFE : 16'($urandom),
                8'($urandom_range(0, 5)), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eeprom_seq.md
Name: eeprom_seq

Overview:
- Command sequencer directly upstream of the byte-level I2C EEPROM engine. The engine's interface is `wr`/`rd`/`addr`/`data_w` in and `ack`/`data_out` back.
- Accepts burst read/write requests of 1–256 bytes at a 16-bit EEPROM address. Splits each burst into single-byte engine transactions and holds `addr`/`data` stable for each one.
- Inserts the EEPROM internal write-cycle delay (tWR) after every byte write, streams read bytes out, and flags engine timeouts.

Parameters:
- ADDR_W, 16, EEPROM byte address width.
- TWR_CYCLES, 50000, idle cycles after each write ack (5 ms at 10 MHz).
- ACK_TIMEOUT, 65535, max cycles from engine pulse to engine ack before error.

Ports:
- clk  in  1  system clock (10 MHz, same clock as the engine).
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  sequencer can accept a request (high only in IDLE).
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  start address.
- req_len  in  8  byte count minus 1 (0 → 1 byte, 255 → 256 bytes).
- wd_data  in  8  write byte stream.
- wd_valid  in  1  write byte valid.
- wd_ready  out  1  write byte accepted this cycle.
- rd_data  out  8  read byte.
- rd_valid  out  1  one-cycle strobe, rd_data valid.
- busy  out  1  burst in progress.
- done  out  1  one-cycle strobe at burst end (success or error).
- err_timeout  out  1  sticky; set on engine timeout, cleared by next accepted request.
- i2c_wr  out  1  one-cycle write command pulse to engine.
- i2c_rd  out  1  one-cycle read command pulse to engine.
- i2c_addr  out  16  engine byte address; held stable from pulse through ack.
- i2c_data_w  out  8  engine write byte; held stable from pulse through ack.
- i2c_ack  in  1  engine one-cycle completion pulse.
- i2c_data_out  in  8  engine read byte, valid when i2c_ack = 1.

Behaviour:
- All outputs are registered. Reset values: req_ready = 0 during rst and 1 the cycle after; all other outputs 0; FSM = IDLE.
- rst must be asserted together with the engine's reset. A reset mid-burst drops the burst with no done strobe.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch addr, len, write; clear err_timeout; busy = 1.
  - Next state: FETCH for a write burst, ISSUE for a read burst.
- FETCH:
  - wd_ready = wd_valid (combinational accept on the registered-state qualifier).
  - On accept, latch the byte into i2c_data_w → ISSUE.
  - Waits indefinitely with no timeout.
- ISSUE:
  - Drive i2c_wr or i2c_rd high for exactly 1 cycle.
  - Load the timeout counter → WAIT_ACK.
- WAIT_ACK:
  - On i2c_ack:
    - Read burst: rd_data = i2c_data_out and rd_valid = 1 on the following cycle → GAP.
    - Write burst: load the tWR counter → TWR.
  - If the counter reaches ACK_TIMEOUT with no ack: set err_timeout, done = 1 → IDLE.
  - i2c_ack arriving outside WAIT_ACK is ignored.
- TWR: count TWR_CYCLES cycles → GAP.
- GAP (1 cycle):
  - If the remaining count is 0: done = 1, busy = 0 → IDLE.
  - Otherwise: address + 1 (wraps FFFF → 0000), remaining − 1 → FETCH for writes, ISSUE for reads.
- Engine spacing: any two engine pulses are separated by at least 2 cycles after the ack cycle, since the engine needs Ackn→Idle. GAP guarantees this.
- Read data has no back-pressure: the consumer must accept rd_valid every strobe.
- Latency:
  - Read byte: rd_valid = 1 cycle after i2c_ack.
  - Request accept → first engine pulse: 2 cycles for reads, 2 cycles after wd accept for writes.
- req_valid while busy: ignored, req_ready = 0.
- Simultaneous i2c_ack and timeout expiry: ack wins.

Decomposition:
- Package eeprom_pkg holds:
  - FSM state encoding (IDLE, FETCH, ISSUE, WAIT_ACK, TWR, GAP).
  - Default TWR_CYCLES and ACK_TIMEOUT constants.
  - EEPROM device-ID constant 3'b000.
- One sub-module: seq_timer, a loadable down-counter with an expiry flag. It is shared by the tWR wait and the ack timeout, since those two are never active at once.

Test Plan:
- Write burst, addr = 0x0010, len = 2, bytes A5/5A/C3; engine model acks 100 cycles after each pulse:
  - 3 i2c_wr pulses with addrs 0x0010/0x0011/0x0012 and matching data.
  - Each pulse ≥ TWR_CYCLES after the prior ack.
  - One done strobe.
- Read burst, addr = 0x0100, len = 3; model returns 11/22/33/44:
  - 4 i2c_rd pulses; rd_valid × 4 with data 11/22/33/44.
  - done once; err_timeout = 0.
- Wrap: read at 0xFFFF, len = 1 → i2c_addr sequence FFFF then 0000.
- Timeout: model never acks, ACK_TIMEOUT = 1000:
  - err_timeout = 1 and done at pulse + 1000.
  - Next request clears err_timeout.
- Write with wd_valid stalled 500 cycles:
  - No i2c_wr pulse during the stall; i2c_addr/i2c_data_w stable pulse→ack.
  - req_valid held during busy is ignored.
- Reset asserted mid-WAIT_ACK: next cycle busy = 0 and i2c_wr = i2c_rd = 0; cycle after, req_ready = 1; no done strobe.
